// File: rtl/aespim_rkey_store_if.sv
// -----------------------------------------------------------------------------
// aespim_rkey_store_if
// Bus bundle between the key-expansion/cipher side (master) and the AES
// round-key store (slave). Signal suffixes are from the store's viewpoint:
//   clear_i     synchronous clear of the store
//   wr_valid_i  key-expansion word valid
//   wr_data_i   key-expansion word w[k], in generation order
//   wr_ready_o  store can accept a word
//   full_o      all round keys stored
//   rd_req_i    round-key read request
//   rd_round_i  requested round index
//   rd_valid_o  rd_key_o holds the requested key (one-cycle pulse)
//   rd_key_o    round key, lane 0 in the most significant word
//   err_o       one-cycle error pulse
// -----------------------------------------------------------------------------
interface aespim_rkey_store_if #(
    parameter int WORD_W = 32
);
    logic                  clear_i;
    logic                  wr_valid_i;
    logic [WORD_W-1:0]     wr_data_i;
    logic                  wr_ready_o;
    logic                  full_o;
    logic                  rd_req_i;
    logic [3:0]            rd_round_i;
    logic                  rd_valid_o;
    logic [4*WORD_W-1:0]   rd_key_o;
    logic                  err_o;

    modport master (
        output clear_i, wr_valid_i, wr_data_i, rd_req_i, rd_round_i,
        input  wr_ready_o, full_o, rd_valid_o, rd_key_o, err_o
    );

    modport slave (
        input  clear_i, wr_valid_i, wr_data_i, rd_req_i, rd_round_i,
        output wr_ready_o, full_o, rd_valid_o, rd_key_o, err_o
    );
endinterface

// File: rtl/aespim_rkey_store.sv
// -----------------------------------------------------------------------------
// aespim_rkey_store
// Stores the 4*(NUM_ROUNDS+1) words produced by AES key expansion and serves
// whole round keys (four words) to the cipher datapath with one-cycle latency.
// Ports:
//   clk_i   single clock, rising edge
//   rst_ni  asynchronous active-low reset (wipes all stored key material)
//   bus     aespim_rkey_store_if.slave: write stream, read request, status
// -----------------------------------------------------------------------------
module aespim_rkey_store #(
    parameter int NUM_ROUNDS = 10,
    parameter int WORD_W     = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    aespim_rkey_store_if.slave        bus
);
    localparam int         NUM_WORDS   = 4 * (NUM_ROUNDS + 1);
    localparam logic [5:0] NUM_WORDS_C = 6'(NUM_WORDS);
    localparam logic [3:0] MAX_ROUND_C = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        FULL
    } state_e;

    state_e                state_q;
    logic [5:0]            count_q;
    logic [WORD_W-1:0]     mem_q [NUM_WORDS];
    logic                  full_q;
    logic                  rd_valid_q;
    logic                  err_q;
    logic [4*WORD_W-1:0]   rd_key_q;
    logic [4*WORD_W-1:0]   rd_key_d;

    logic                  wr_acc;
    logic                  wr_drop;
    logic                  wr_last;
    logic                  rd_legal;
    logic [6:0]            rd_need;
    logic [5:0]            rd_base;

    assign bus.wr_ready_o = (state_q != FULL);
    assign bus.full_o     = full_q;
    assign bus.rd_valid_o = rd_valid_q;
    assign bus.rd_key_o   = rd_key_q;
    assign bus.err_o      = err_q;

    assign wr_acc  = bus.wr_valid_i && (state_q != FULL);
    assign wr_drop = bus.wr_valid_i && (state_q == FULL);
    assign wr_last = (count_q == (NUM_WORDS_C - 6'd1));

    // A round is readable only once all four of its words were stored on an
    // earlier edge; count_q is the pre-write value, so a write completing the
    // round in this same cycle does not make the read legal.
    assign rd_need  = {1'b0, bus.rd_round_i, 2'b00} + 7'd4;
    assign rd_legal = (bus.rd_round_i <= MAX_ROUND_C) && (rd_need <= {1'b0, count_q});
    // Base index forced to 0 for illegal rounds so the array read stays in range.
    assign rd_base  = rd_legal ? {bus.rd_round_i, 2'b00} : 6'd0;

    always_comb begin
        rd_key_d = '0;
        for (int l = 0; l < 4; l++) begin
            rd_key_d[(3-l)*WORD_W +: WORD_W] = mem_q[rd_base + 6'(l)];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= EMPTY;
            count_q    <= '0;
            full_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            rd_key_q   <= '0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (bus.clear_i) begin
            // Clear wins over any same-cycle write or read and wipes the keys.
            state_q    <= EMPTY;
            count_q    <= '0;
            full_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            rd_key_q   <= '0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_valid_q <= bus.rd_req_i && rd_legal;
            // Dropped write and illegal read in one cycle merge into one pulse.
            err_q      <= wr_drop || (bus.rd_req_i && !rd_legal);
            if (bus.rd_req_i && rd_legal) begin
                rd_key_q <= rd_key_d;
            end
            if (wr_acc) begin
                mem_q[count_q] <= bus.wr_data_i;
                count_q        <= count_q + 6'd1;
                if (wr_last) begin
                    state_q <= FULL;
                    full_q  <= 1'b1;
                end else begin
                    state_q <= FILL;
                end
            end
        end
    end
endmodule

// File: tb/tb_aespim_rkey_store.sv
// -----------------------------------------------------------------------------
// tb_aespim_rkey_store
// Self-checking bench for the AES round-key store. The reference derives key
// expansion words from an AES-128 key using a GF(2^8) S-box computed on the
// fly, and tracks the store as a plain array plus word count.
// -----------------------------------------------------------------------------
module tb_aespim_rkey_store;
    localparam int WORD_W = 32;
    localparam int NW     = 44;

    logic clk;
    logic rst_n;

    aespim_rkey_store_if #(.WORD_W(WORD_W)) bus ();

    aespim_rkey_store #(.NUM_ROUNDS(10), .WORD_W(WORD_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0]  kw [NW];     // expansion words of the current key
    logic [31:0]  mw [NW];     // reference store contents
    int           m_cnt;       // reference word count
    logic [127:0] m_key;       // reference rd_key_o

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- AES-128 key expansion reference ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        if (x == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    task automatic expand(input logic [127:0] key);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) kw[i] = key[127-32*i -: 32];
        for (int i = 4; i < NW; i++) begin
            t = kw[i-1];
            if (i % 4 == 0) begin
                t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            kw[i] = kw[i-4] ^ t;
        end
    endtask

    task automatic model_wipe();
        for (int i = 0; i < NW; i++) mw[i] = 32'h0;
        m_cnt = 0;
        m_key = 128'h0;
    endtask

    task automatic idle_inputs();
        bus.clear_i    = 1'b0;
        bus.wr_valid_i = 1'b0;
        bus.wr_data_i  = 32'h0;
        bus.rd_req_i   = 1'b0;
        bus.rd_round_i = 4'h0;
    endtask

    // One clock: drive, advance past the edge, update reference, compare.
    task automatic cyc(input logic wv, input logic [31:0] wd, input logic rq,
                       input logic [3:0] rr, input logic clr, input string tag);
        bit legal, acc, drop, e_val, e_err;
        bus.clear_i    = clr;
        bus.wr_valid_i = wv;
        bus.wr_data_i  = wd;
        bus.rd_req_i   = rq;
        bus.rd_round_i = rr;
        legal = (int'(rr) <= 10) && (4 * int'(rr) + 4 <= m_cnt);
        acc   = wv && (m_cnt < NW);
        drop  = wv && (m_cnt == NW);
        @(posedge clk);
        #1;
        if (clr) begin
            model_wipe();
            e_val = 1'b0;
            e_err = 1'b0;
        end else begin
            e_val = rq && legal;
            e_err = drop || (rq && !legal);
            if (e_val) m_key = {mw[4*rr], mw[4*rr+1], mw[4*rr+2], mw[4*rr+3]};
            if (acc) begin
                mw[m_cnt] = wd;
                m_cnt++;
            end
        end
        check_eq({tag, ".rd_valid"}, 128'(bus.rd_valid_o), 128'(e_val));
        check_eq({tag, ".err"},      128'(bus.err_o),      128'(e_err));
        check_eq({tag, ".rd_key"},   bus.rd_key_o,         m_key);
        check_eq({tag, ".full"},     128'(bus.full_o),     128'(m_cnt == NW));
        check_eq({tag, ".wr_ready"}, 128'(bus.wr_ready_o), 128'(m_cnt < NW));
        idle_inputs();
    endtask

    task automatic fill_n(input int n, input string tag);
        for (int k = 0; k < n; k++) cyc(1'b1, kw[m_cnt], 1'b0, 4'd0, 1'b0, tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".wr_ready"}, 128'(bus.wr_ready_o), 128'(1));
        check_eq({tag, ".full"},     128'(bus.full_o),     128'(0));
        check_eq({tag, ".rd_valid"}, 128'(bus.rd_valid_o), 128'(0));
        check_eq({tag, ".err"},      128'(bus.err_o),      128'(0));
        check_eq({tag, ".rd_key"},   bus.rd_key_o,         128'h0);
    endtask

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    initial begin
        logic [3:0]  rr;
        logic        wv, rq, clr;
        logic [31:0] wd;

        idle_inputs();
        rst_n = 1'b0;
        model_wipe();
        expand(FIPS_KEY);
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-back fill with the FIPS-197 example key, then known reads.
        fill_n(NW, "fips_fill");
        cyc(1'b0, 32'h0, 1'b1, 4'd0, 1'b0, "rd_r0");
        check_eq("fips_r0", bus.rd_key_o, FIPS_KEY);
        cyc(1'b0, 32'h0, 1'b1, 4'd1, 1'b0, "rd_r1");
        check_eq("fips_r1", bus.rd_key_o, FIPS_R1);
        cyc(1'b0, 32'h0, 1'b1, 4'd10, 1'b0, "rd_r10");
        check_eq("fips_r10", bus.rd_key_o, FIPS_R10);

        // Overflow write, out-of-range read, and both together.
        cyc(1'b1, 32'hdeadbeef, 1'b0, 4'd0, 1'b0, "overflow");
        cyc(1'b0, 32'h0, 1'b1, 4'd10, 1'b0, "rd_r10_after_ovf");
        check_eq("r10_unchanged", bus.rd_key_o, FIPS_R10);
        cyc(1'b0, 32'h0, 1'b1, 4'd11, 1'b0, "rd_r11");
        check_eq("r11_key_hold", bus.rd_key_o, FIPS_R10);
        cyc(1'b1, 32'h12345678, 1'b1, 4'd15, 1'b0, "drop_and_bad_rd");
        cyc(1'b0, 32'h0, 1'b0, 4'd0, 1'b0, "err_single_pulse");

        // Clear, partial fill, early read, same-edge completion.
        cyc(1'b1, 32'h0, 1'b1, 4'd0, 1'b1, "clear_prio");
        fill_n(6, "part_fill");
        cyc(1'b0, 32'h0, 1'b1, 4'd1, 1'b0, "rd_r1_partial");
        fill_n(1, "part_fill7");
        cyc(1'b1, kw[7], 1'b1, 4'd1, 1'b0, "same_edge");
        cyc(1'b0, 32'h0, 1'b1, 4'd1, 1'b0, "next_cycle_r1");
        check_eq("same_edge_r1", bus.rd_key_o, FIPS_R1);
        fill_n(12, "to20");
        cyc(1'b0, 32'h0, 1'b0, 4'd0, 1'b1, "clear_mid");
        cyc(1'b0, 32'h0, 1'b1, 4'd0, 1'b0, "rd_r0_after_clear");
        fill_n(NW, "refill");
        cyc(1'b0, 32'h0, 1'b1, 4'd10, 1'b0, "refill_r10");
        check_eq("refill_r10_const", bus.rd_key_o, FIPS_R10);

        // Asynchronous reset mid-fill with a legal read and a write pending.
        cyc(1'b0, 32'h0, 1'b0, 4'd0, 1'b1, "clear2");
        fill_n(20, "to20b");
        bus.wr_valid_i = 1'b1;
        bus.wr_data_i  = kw[20];
        bus.rd_req_i   = 1'b1;
        bus.rd_round_i = 4'd2;
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        idle_inputs();
        model_wipe();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        cyc(1'b0, 32'h0, 1'b0, 4'd0, 1'b0, "post_rst_quiet");
        cyc(1'b0, 32'h0, 1'b1, 4'd0, 1'b0, "rd_r0_after_rst");
        fill_n(NW, "refill2");
        cyc(1'b0, 32'h0, 1'b1, 4'd1, 1'b0, "refill2_r1");
        check_eq("refill2_r1_const", bus.rd_key_o, FIPS_R1);

        // Randomised traffic with fresh keys after every clear.
        cyc(1'b0, 32'h0, 1'b0, 4'd0, 1'b1, "rnd_clear");
        expand({$urandom, $urandom, $urandom, $urandom});
        for (int n = 0; n < 900; n++) begin
            clr = ($urandom_range(0, 99) < 2) || ((m_cnt == NW) && ($urandom_range(0, 19) == 0));
            wv  = ($urandom_range(0, 99) < 70);
            wd  = (m_cnt < NW) ? kw[m_cnt] : $urandom;
            rq  = $urandom_range(0, 1) == 1;
            rr  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 10));
            cyc(wv, wd, rq, rr, clr, "rnd");
            if (clr) expand({$urandom, $urandom, $urandom, $urandom});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/aespim_rkey_store.md
AESPIM_RKEY_STORE -- requirements
Module: aespim_rkey_store

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NUM_ROUNDS  10  number of cipher rounds; NUM_ROUNDS+1 round keys are stored, 4*(NUM_ROUNDS+1) words total (44 at default).
  WORD_W  32  width of one key-expansion word.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk_i  in  1  single clock; all state updates on the rising edge.
  rst_ni  in  1  asynchronous, active-low reset.
  clear_i  in  1  synchronous clear of store and fill state.
  wr_valid_i  in  1  key-expansion output word is valid.
  wr_data_i  in  WORD_W  key-expansion word w[k], in generation order.
  wr_ready_o  out  1  store can accept a word.
  full_o  out  1  all 4*(NUM_ROUNDS+1) words stored.
  rd_req_i  in  1  round-key read request from the cipher datapath.
  rd_round_i  in  4  requested round index.
  rd_valid_o  out  1  rd_key_o holds the requested key; one-cycle pulse.
  rd_key_o  out  4*WORD_W  round key.
  err_o  out  1  one-cycle error pulse.

Function
REQ-003 The block SHALL implement three states: EMPTY (count 0), FILL (0 < count < 4*(NUM_ROUNDS+1)), FULL (count = 4*(NUM_ROUNDS+1)).
REQ-004 count SHALL be a 6-bit word counter; a write is accepted when wr_valid_i && wr_ready_o, storing w[k] at round k/4, lane k%4, and incrementing count.
REQ-005 Lane 0 SHALL occupy rd_key_o[4*WORD_W-1 -: WORD_W]; lane 3 SHALL occupy bits [WORD_W-1:0].
REQ-006 wr_ready_o SHALL be combinational: 1 in EMPTY and FILL, 0 in FULL.
REQ-007 Transitions: EMPTY->FILL on the first accepted write; FILL->FULL on the accept that makes count 44; FULL->EMPTY only on clear_i or reset.
REQ-008 full_o SHALL be registered and assert the cycle after the final accept.
REQ-009 wr_valid_i in FULL SHALL be dropped: no store change, err_o=1 next cycle.
REQ-010 A read is legal when rd_round_i <= NUM_ROUNDS and 4*rd_round_i+4 <= count, with count sampled before any same-edge write.
REQ-011 A legal read SHALL produce rd_valid_o=1 and rd_key_o=key one cycle after rd_req_i (latency 1); rd_req_i may be asserted every cycle.
REQ-012 An illegal read SHALL produce rd_valid_o=0, err_o=1 next cycle; rd_key_o SHALL hold its previous value.
REQ-013 A simultaneous write completing round r and read of round r SHALL be illegal; a read of round r the following cycle SHALL be legal.
REQ-014 If a dropped write and an illegal read occur in the same cycle, a single err_o pulse SHALL be produced.
REQ-015 clear_i SHALL have priority over writes and reads: next cycle state EMPTY, count 0, all stored words 0, full_o 0, rd_valid_o 0, err_o 0, rd_key_o 0.
REQ-016 Stored words SHALL never be readable after clear_i or reset (key hygiene).

Reset
REQ-017 On rst_ni low, immediately and independent of clk_i: state EMPTY, count 0, storage 0, full_o 0, rd_valid_o 0, err_o 0, rd_key_o 0; wr_ready_o SHALL be 1.
REQ-018 Reset asserted mid-fill or mid-read SHALL discard the operation; no rd_valid_o or err_o pulse SHALL follow deassertion.

Verification
REQ-019 Reset: rst_ni=0 -> wr_ready_o=1, full_o=0, rd_valid_o=0, err_o=0, rd_key_o=0.
REQ-020 Fill: 44 FIPS-197 words for key 2b7e151628aed2a6abf7158809cf4f3c written back-to-back -> full_o=1 after the last write. Reads:
  round 0 -> 2b7e151628aed2a6abf7158809cf4f3c;
  round 1 -> a0fafe1788542cb123a339392a6c7605;
  round 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6;
  each one cycle after rd_req_i, with rd_valid_o=1.
REQ-021 Partial and overflow: after 6 words, a read of round 1 -> err_o pulse, rd_valid_o=0. After 44 words, a 45th write -> dropped, err_o pulse, round 10 unchanged.
REQ-022 Range: rd_round_i=11 with store FULL -> err_o pulse, rd_key_o unchanged.
REQ-023 Same-edge: write w[7] and read round 1 together -> err_o; read round 1 the next cycle -> a0fafe17...7605 valid.
REQ-024 Clear/reset mid-fill: clear_i (then separately rst_ni) after 20 words -> EMPTY; a read of round 0 -> err_o; a refill of 44 words -> correct keys.
